// File: rtl/spi_cmd_ctrl.sv
// Command/register controller behind the 16-bit SPI slave.
// Decodes header-plus-burst transactions from received words, drives a bank
// of writable configuration registers, muxes read-only status words and
// sequences txd_data so the host reads back on the following frames.
module spi_cmd_ctrl #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned NUM_STAT = 4,
  parameter logic [15:0] REG_RST  = 16'h0000,
  parameter logic [15:0] ID_WORD  = 16'hA55A
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cs_n,
  input  logic                   rxd_flag_p,
  input  logic [15:0]            rxd_data,
  output logic [15:0]            txd_data,
  output logic [NUM_REGS*16-1:0] reg_q,
  input  logic [NUM_STAT*16-1:0] stat_in,
  output logic                   wr_stb,
  output logic [7:0]             wr_addr,
  output logic                   err
);

  localparam logic [7:0] NumRegsW = 8'(NUM_REGS);
  localparam logic [7:0] AddrClr  = 8'hFE;
  localparam logic [7:0] AddrId   = 8'hFF;

  typedef enum logic [1:0] {StIdle, StWrData, StRdData} state_e;

  state_e      state_q, state_d;
  logic [4:0]  rem_q, rem_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] txd_q, txd_d;
  logic        err_q, err_d;
  logic        wr_stb_q, wr_stb_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic        wr_en;
  logic        err_set, err_clr;
  logic [7:0]  rd_addr;
  logic [15:0] rd_word;
  logic [15:0] regs_q [NUM_REGS];

  // Read map: header address while idle, otherwise the next burst address.
  always_comb begin
    rd_addr = (state_q == StIdle) ? rxd_data[7:0] : addr_q + 8'd1;
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == 8'(i)) rd_word = regs_q[i];
    end
    for (int unsigned i = 0; i < NUM_STAT; i++) begin
      if (rd_addr == 8'(32'h80 + i)) rd_word = stat_in[16*i +: 16];
    end
    if (rd_addr == AddrId) rd_word = ID_WORD;
  end

  // Next-state and datapath decode for each received word.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    txd_d     = txd_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_en     = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;

    if (rxd_flag_p) begin
      unique case (state_q)
        StIdle: begin
          addr_d = rxd_data[7:0];
          rem_d  = {1'b0, rxd_data[11:8]} + 5'd1;
          if (rxd_data[15]) begin
            txd_d   = '0;
            state_d = StWrData;
          end else begin
            txd_d   = rd_word;
            state_d = StRdData;
          end
          // A header arriving outside a frame is a protocol error.
          if (cs_n) err_set = 1'b1;
        end
        StWrData: begin
          if (rem_q == 5'd0) begin
            err_set = 1'b1;
            state_d = StIdle;
          end else begin
            if (addr_q < NumRegsW) begin
              wr_en     = 1'b1;
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_q;
            end else if (addr_q == AddrClr) begin
              err_clr = 1'b1;
            end else begin
              err_set = 1'b1;
            end
            txd_d  = rxd_data;
            addr_d = addr_q + 8'd1;
            rem_d  = rem_q - 5'd1;
            if (rem_q == 5'd1) state_d = StIdle;
          end
        end
        StRdData: begin
          if (rem_q == 5'd0) begin
            err_set = 1'b1;
            state_d = StIdle;
          end else begin
            rem_d = rem_q - 5'd1;
            if (rem_q > 5'd1) begin
              addr_d = addr_q + 8'd1;
              txd_d  = rd_word;
            end else begin
              txd_d   = '0;
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Frame abort only overrides sequencing; the flagged word still took effect.
    if (cs_n) begin
      state_d = StIdle;
      rem_d   = '0;
    end

    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      addr_q    <= '0;
      txd_q     <= '0;
      err_q     <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      txd_q     <= txd_d;
      err_q     <= err_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Writable register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RST;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (addr_q == 8'(i)) regs_q[i] <= rxd_data;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_flat
    assign reg_q[16*gi +: 16] = regs_q[gi];
  end

  assign txd_data = txd_q;
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;
  assign err      = err_q;

endmodule
